// File: rtl/feistel_lr_core.sv
`default_nettype none
// ============================================================================
// Module   : feistel_lr_core
// Purpose  : Feistel L/R state engine with round control, valid/ready in/out.
// Revision : 1.0 - initial release
// ============================================================================
module feistel_lr_core #(
  parameter  int HALF_W = 32,
  parameter  int ROUNDS = 16,
  localparam int CNT_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [2*HALF_W-1:0] block_in,
  input  logic                decrypt,
  input  logic [HALF_W-1:0]   f_out,
  output logic [HALF_W-1:0]   R_curr,
  output logic [CNT_W-1:0]    round_cnt,
  output logic [CNT_W-1:0]    key_idx,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*HALF_W-1:0] block_out
);

  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [HALF_W-1:0]  l_q, l_d;
  logic [HALF_W-1:0]  r_q, r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      l_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (flush) begin
      state_d = S_IDLE;
      l_d     = '0;
      r_d     = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_valid && start_ready) begin
            l_d     = block_in[2*HALF_W-1:HALF_W];
            r_d     = block_in[HALF_W-1:0];
            cnt_d   = '0;
            mode_d  = decrypt;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          l_d = r_q;
          r_d = l_q ^ f_out;
          // The counter parks on the last round so it never wraps.
          if (cnt_q == LAST_RND) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == S_IDLE) && !rst;
  assign busy        = (state_q == S_RUN);
  assign out_valid   = (state_q == S_DONE);
  assign R_curr      = r_q;
  assign round_cnt   = cnt_q;
  assign key_idx     = mode_q ? (LAST_RND - cnt_q) : cnt_q;
  assign block_out   = {r_q, l_q};

endmodule
`default_nettype wire
